// File: rtl/jam_divider_pkg.sv
// Shared types and constants for the JAM-preset down-counting divider.
package jam_divider_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Largest preset accepted in decade mode.
  localparam int DECADE_MAX    = 9;
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/jam_down_divider.sv
// Presettable down-counter used as a programmable divide-by-N.
// Loads N from JAM and counts down once per enabled clock. At the
// terminal count it emits a one-cycle TC pulse and toggles DIV_OUT.
// It then either reloads N (AUTO_RELOAD=1) or stops in IDLE (AUTO_RELOAD=0).
// Build option: JAM_DIVIDER_DECADE_EN clamps any loaded JAM above 9 down to 9.
// That option needs WIDTH >= 4.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | counter halted, Q holds its last value
// RUN   | counting down toward 1 on each enabled clock
module jam_down_divider
  import jam_divider_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             CLOCK,
  input  logic             PRESET_ENABLE,
  input  logic             JAM_LOAD,
  input  logic             CARRY_IN_N,
  input  logic [WIDTH-1:0] JAM,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             DIV_OUT,
  output logic             BUSY
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_div;
  logic [WIDTH-1:0] w_jam_eff;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_reload_next;
  logic             w_tc_next;
  logic             w_div_next;

`ifdef JAM_DIVIDER_DECADE_EN
  // Decade mode: clamp the preset so N never exceeds 9.
  always_comb begin
    w_jam_eff = JAM;
    if (JAM > WIDTH'(DECADE_MAX)) w_jam_eff = WIDTH'(DECADE_MAX);
  end
`else
  // Binary mode: the preset is used as given.
  always_comb begin
    w_jam_eff = JAM;
  end
`endif

  // Next-state and next-count logic.
  // A load wins over counting, and TC is only ever a one-cycle pulse.
  always_comb begin
    w_state_next  = r_state;
    w_q_next      = r_q;
    w_reload_next = r_reload;
    w_tc_next     = 1'b0;
    w_div_next    = r_div;
    if (JAM_LOAD) begin
      // A zero preset means divide-by-zero, which leaves the counter stopped.
      w_reload_next = w_jam_eff;
      w_q_next      = w_jam_eff;
      w_state_next  = (w_jam_eff != '0) ? ST_RUN : ST_IDLE;
    end else if ((r_state == ST_RUN) && !CARRY_IN_N) begin
      if (r_q == WIDTH'(1)) begin
        w_tc_next  = 1'b1;
        w_div_next = ~r_div;
        if (AUTO_RELOAD) begin
          w_q_next = r_reload;
        end else begin
          w_q_next     = '0;
          w_state_next = ST_IDLE;
        end
      end else begin
        w_q_next = r_q - WIDTH'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (PRESET_ENABLE) r_state <= ST_IDLE;
    else               r_state <= w_state_next;
  end

  // Count, reload and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (PRESET_ENABLE) begin
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_div    <= 1'b0;
    end else begin
      r_q      <= w_q_next;
      r_reload <= w_reload_next;
      r_tc     <= w_tc_next;
      r_div    <= w_div_next;
    end
  end

  assign Q       = r_q;
  assign TC      = r_tc;
  assign DIV_OUT = r_div;
  assign BUSY    = (r_state == ST_RUN);

endmodule

// File: tb/tb_jam_down_divider.sv
// Bench for jam_down_divider.
// Two instances share the same stimulus: one with AUTO_RELOAD=1, one with AUTO_RELOAD=0.
// Both are compared every cycle against a behavioural model of the divider.
module tb_jam_down_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic         cin_n;
  logic [W-1:0] jam;

  logic [W-1:0] q_ar, q_os;
  logic         tc_ar, tc_os, div_ar, div_os, busy_ar, busy_os;

  int n_chk = 0;
  int n_bad = 0;

  // Model state, index 0 = auto-reload instance, 1 = one-shot instance.
  int m_q[2], m_rl[2], m_tc[2], m_div[2], m_busy[2];

  always #5 clk = ~clk;

  jam_down_divider #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
    .CLOCK(clk), .PRESET_ENABLE(rst), .JAM_LOAD(load), .CARRY_IN_N(cin_n),
    .JAM(jam), .Q(q_ar), .TC(tc_ar), .DIV_OUT(div_ar), .BUSY(busy_ar));

  jam_down_divider #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_os (
    .CLOCK(clk), .PRESET_ENABLE(rst), .JAM_LOAD(load), .CARRY_IN_N(cin_n),
    .JAM(jam), .Q(q_os), .TC(tc_os), .DIV_OUT(div_os), .BUSY(busy_os));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_n(input int j);
`ifdef JAM_DIVIDER_DECADE_EN
    return (j > 9) ? 9 : j;
`else
    return j;
`endif
  endfunction

  // Divider behaviour for one rising edge.
  task automatic model_step(input int k, input bit ar);
    if (rst) begin
      m_q[k] = 0; m_rl[k] = 0; m_tc[k] = 0; m_div[k] = 0; m_busy[k] = 0;
    end else if (load) begin
      m_rl[k]   = eff_n(int'(jam));
      m_q[k]    = m_rl[k];
      m_tc[k]   = 0;
      m_busy[k] = (m_rl[k] != 0);
    end else if (m_busy[k] != 0 && !cin_n) begin
      if (m_q[k] > 1) begin
        m_q[k]  = m_q[k] - 1;
        m_tc[k] = 0;
      end else begin
        m_tc[k]  = 1;
        m_div[k] = 1 - m_div[k];
        if (ar) m_q[k] = m_rl[k];
        else begin
          m_q[k] = 0; m_busy[k] = 0;
        end
      end
    end else begin
      m_tc[k] = 0;
    end
  endtask

  // Apply inputs for one cycle, advance the model and compare both instances.
  task automatic cyc(input bit r, input bit l, input bit c, input int j);
    rst = r; load = l; cin_n = c; jam = W'(j);
    @(posedge clk);
    #1;
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    chk("q_ar",    32'(q_ar),    32'(m_q[0]));
    chk("tc_ar",   32'(tc_ar),   32'(m_tc[0]));
    chk("div_ar",  32'(div_ar),  32'(m_div[0]));
    chk("busy_ar", 32'(busy_ar), 32'(m_busy[0]));
    chk("q_os",    32'(q_os),    32'(m_q[1]));
    chk("tc_os",   32'(tc_os),   32'(m_tc[1]));
    chk("div_os",  32'(div_os),  32'(m_div[1]));
    chk("busy_os", 32'(busy_os), 32'(m_busy[1]));
  endtask

  int tcs_ar, tcs_os, last_tc, gap;
  int exp_big;

  initial begin
    rst = 1'b1; load = 1'b0; cin_n = 1'b1; jam = '0;
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_rl[k] = 0; m_tc[k] = 0; m_div[k] = 0; m_busy[k] = 0;
    end

    // Reset must win over a simultaneous load.
    cyc(1, 1, 0, 5);
    cyc(1, 1, 0, 5);
    chk("rst_q",    32'(q_ar),    32'd0);
    chk("rst_tc",   32'(tc_ar),   32'd0);
    chk("rst_div",  32'(div_ar),  32'd0);
    chk("rst_busy", 32'(busy_ar), 32'd0);

    // Divide by 3: four TC pulses in 12 enabled cycles, and Q shows 3 on every TC.
    cyc(0, 1, 0, 3);
    chk("load3_q", 32'(q_ar), 32'd3);
    tcs_ar = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0);
      if (tc_ar) begin
        tcs_ar++;
        chk("tc_at_q3", 32'(q_ar), 32'd3);
      end
    end
    chk("div3_tcs", 32'(tcs_ar), 32'd4);

    // Divide by 4 with a two-cycle hold mid-count: that one TC gap stretches to 6.
    cyc(0, 1, 0, 4);
    last_tc = -1; gap = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, (i == 5 || i == 6), 0);
      if (tc_ar) begin
        if (last_tc >= 0 && gap == 0) gap = i - last_tc;
        last_tc = i;
      end
    end
    chk("hold_gap", 32'(gap), 32'd6);

    // The one-shot instance on a load of 2: Q goes 2,1,0, then exactly one TC and BUSY drops.
    cyc(0, 1, 0, 2);
    tcs_os = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      if (tc_os) tcs_os++;
    end
    chk("os_tcs",  32'(tcs_os),  32'd1);
    chk("os_q",    32'(q_os),    32'd0);
    chk("os_busy", 32'(busy_os), 32'd0);

    // A load of 0 stops the counter: no TC for 20 cycles.
    cyc(0, 1, 0, 0);
    tcs_ar = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      if (tc_ar) tcs_ar++;
    end
    chk("n0_tcs",  32'(tcs_ar),  32'd0);
    chk("n0_busy", 32'(busy_ar), 32'd0);

    // A load of 1 makes TC high on every cycle.
    cyc(0, 1, 0, 1);
    tcs_ar = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      if (tc_ar) tcs_ar++;
    end
    chk("n1_tcs", 32'(tcs_ar), 32'd6);

    // JAM=12: decade mode clamps it to 9, binary mode keeps 12.
`ifdef JAM_DIVIDER_DECADE_EN
    exp_big = 9;
`else
    exp_big = 12;
`endif
    cyc(0, 1, 0, 12);
    chk("big_q", 32'(q_ar), 32'(exp_big));
    last_tc = -1; gap = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0, 0);
      if (tc_ar) begin
        if (last_tc >= 0 && gap == 0) gap = i - last_tc;
        last_tc = i;
      end
    end
    chk("big_gap", 32'(gap), 32'(exp_big));

    // Randomized traffic: rare resets, occasional loads, holds, and random presets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, (1 << W) - 1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
